// File: rtl/cpu_datapath.sv
// cpu_datapath: 8-bit accumulator datapath with PC, IR, register file, ALU and Z/C flags
module cpu_datapath #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int NREG = 16
) (
  input  logic          CLK,
  input  logic          CLB,
  input  logic          LoadIR,
  input  logic          IncPC,
  input  logic          SelPC,
  input  logic          LoadPC,
  input  logic          LoadReg,
  input  logic          LoadAcc,
  input  logic [1:0]    SelAcc,
  input  logic [3:0]    SelALU,
  input  logic [DW-1:0] InstrIn,
  output logic [AW-1:0] PCAddr,
  output logic [7:0]    Opcode,
  output logic          Z,
  output logic          C,
  output logic [DW-1:0] AccOut
);
  localparam int RW = $clog2(NREG);
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir, r_acc;
  logic          r_z, r_c;
  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] w_b, w_res, w_acc_src, w_pc_src;
  logic          w_co;
  logic [DW:0]   w_sum, w_dif;
  assign w_b       = r_regs[r_ir[RW-1:0]];
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_b};
  assign w_dif     = {1'b0, r_acc} - {1'b0, w_b};
  assign w_acc_src = SelAcc == 2'b00 ? '0 : SelAcc == 2'b01 ? InstrIn : SelAcc == 2'b10 ? w_res : w_b;
  assign w_pc_src  = SelPC ? InstrIn : w_b;
  assign PCAddr    = r_pc;
  assign Opcode    = 8'(r_ir);
  assign Z         = r_z;
  assign C         = r_c;
  assign AccOut    = r_acc;
  // ALU: A = Acc, B = Reg[IR]; the top bit of the subtract is the borrow
  always_comb begin
    w_res = r_acc;
    w_co  = 1'b0;
    case (SelALU)
      4'h0: w_res = w_b;
      4'h2: {w_co, w_res} = w_sum;
      4'h3: {w_co, w_res} = w_dif;
      4'h4: w_res = ~(r_acc | w_b);
      4'h5: w_res = r_acc & w_b;
      4'h6: w_res = r_acc | w_b;
      4'h7: w_res = r_acc ^ w_b;
      default: w_res = r_acc;
    endcase
  end
  // State update; all sources read pre-edge values, LoadPC beats IncPC, flags move only on ALU loads
  always_ff @(posedge CLK) begin
    if (CLB) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_acc <= '0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (LoadIR) r_ir <= InstrIn;
      if (LoadPC) r_pc <= AW'(w_pc_src);
      else if (IncPC) r_pc <= r_pc + 1'b1;
      if (LoadReg) r_regs[r_ir[RW-1:0]] <= r_acc;
      if (LoadAcc) r_acc <= w_acc_src;
      if (LoadAcc && SelAcc == 2'b10) begin
        r_z <= w_res == '0;
        r_c <= w_co;
      end
    end
  end
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed plus randomized checks of cpu_datapath against an arithmetic reference model
module tb_cpu_datapath;
  logic       CLK = 0, CLB, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;
  logic [7:0] InstrIn, PCAddr, Opcode, AccOut;
  logic       Z, C;
  int n_chk = 0, n_err = 0;
  int m_pc, m_ir, m_acc, m_z, m_c;
  int m_reg [16];

  cpu_datapath dut (
    .CLK(CLK), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU), .InstrIn(InstrIn),
    .PCAddr(PCAddr), .Opcode(Opcode), .Z(Z), .C(C), .AccOut(AccOut)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: drive controls, advance the model, compare every output after the edge
  task automatic cyc(input bit clb, lir, ipc, spc, lpc, lreg, lacc,
                     input bit [1:0] sacc, input bit [3:0] salu, input bit [7:0] din);
    int a, b, r, co;
    CLB = clb; LoadIR = lir; IncPC = ipc; SelPC = spc; LoadPC = lpc;
    LoadReg = lreg; LoadAcc = lacc; SelAcc = sacc; SelALU = salu; InstrIn = din;
    a = m_acc;
    b = m_reg[m_ir % 16];
    co = 0;
    if (salu == 0) r = b;
    else if (salu == 2) begin r = (a + b) % 256; co = (a + b > 255); end
    else if (salu == 3) begin r = (a - b + 256) % 256; co = (a < b); end
    else if (salu == 4) r = 255 - (a | b);
    else if (salu == 5) r = a & b;
    else if (salu == 6) r = a | b;
    else if (salu == 7) r = a ^ b;
    else r = a;
    @(posedge CLK); #1;
    if (clb) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
      foreach (m_reg[i]) m_reg[i] = 0;
    end else begin
      if (lreg) m_reg[m_ir % 16] = a;
      if (lacc) begin
        m_acc = sacc == 0 ? 0 : sacc == 1 ? int'(din) : sacc == 2 ? r : b;
        if (sacc == 2) begin m_z = (r == 0); m_c = co; end
      end
      if (lpc) m_pc = spc ? int'(din) : b;
      else if (ipc) m_pc = (m_pc + 1) % 256;
      if (lir) m_ir = din;
    end
    check("pc", PCAddr, m_pc);
    check("ir", Opcode, m_ir);
    check("acc", AccOut, m_acc);
    check("z", Z, m_z);
    check("c", C, m_c);
  endtask

  task automatic ld_ir(input bit [7:0] v);  cyc(0,1,0,0,0,0,0,2'd0,4'd0,v); endtask
  task automatic ld_imm(input bit [7:0] v); cyc(0,0,0,0,0,0,1,2'd1,4'd0,v); endtask
  task automatic ld_reg();                  cyc(0,0,0,0,0,1,0,2'd0,4'd0,8'h00); endtask
  task automatic alu(input bit [3:0] op);   cyc(0,0,0,0,0,0,1,2'd2,op,8'h00); endtask

  initial begin
    m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0;
    foreach (m_reg[i]) m_reg[i] = 0;
    repeat (2) cyc(1,1,1,1,1,1,1,2'd3,4'd2,8'hAA);
    check("rst_pc", PCAddr, 0); check("rst_ir", Opcode, 0); check("rst_acc", AccOut, 0);
    check("rst_z", Z, 0); check("rst_c", C, 0);
    for (int k = 0; k < 16; k++) begin
      ld_ir(8'(k));
      cyc(0,0,0,0,0,0,1,2'd3,4'd0,8'h77);
      check("rst_reg", AccOut, 0);
    end
    ld_ir(8'h03); ld_imm(8'h20); ld_reg(); ld_imm(8'hF0); alu(4'h2);
    check("add_acc", AccOut, 'h10); check("add_c", C, 1); check("add_z", Z, 0);
    ld_imm(8'h10); ld_reg(); ld_imm(8'hF0); alu(4'h2);
    check("add0_acc", AccOut, 0); check("add0_z", Z, 1); check("add0_c", C, 1);
    ld_imm(8'h55);
    check("hold_acc", AccOut, 'h55); check("hold_z", Z, 1); check("hold_c", C, 1);
    ld_ir(8'h01); ld_imm(8'h07); ld_reg(); ld_imm(8'h05); alu(4'h3);
    check("sub_acc", AccOut, 'hFE); check("sub_c", C, 1); check("sub_z", Z, 0);
    ld_imm(8'h07); alu(4'h3);
    check("sub0_acc", AccOut, 0); check("sub0_z", Z, 1); check("sub0_c", C, 0);
    cyc(0,0,0,1,1,0,0,2'd0,4'd0,8'hFF);
    cyc(0,0,1,0,0,0,0,2'd0,4'd0,8'h00);
    check("pc_wrap", PCAddr, 0);
    cyc(0,0,1,1,1,0,0,2'd0,4'd0,8'h40);
    check("pc_prio", PCAddr, 'h40);
    ld_ir(8'h05); ld_imm(8'h9A); ld_reg();
    cyc(0,0,0,0,1,0,0,2'd0,4'd0,8'h00);
    check("pc_reg", PCAddr, 'h9A);
    ld_imm(8'h11); ld_ir(8'h02);
    cyc(0,0,0,0,0,1,1,2'd1,4'd0,8'h22);
    check("same_acc", AccOut, 'h22);
    cyc(0,0,0,0,0,0,1,2'd3,4'd0,8'h00);
    check("same_reg", AccOut, 'h11);
    cyc(0,1,0,1,1,0,0,2'd0,4'd0,8'h3C);
    check("irpc_ir", Opcode, 'h3C); check("irpc_pc", PCAddr, 'h3C);
    for (int n = 0; n < 600; n++) begin
      bit [9:0] c = 10'($urandom);
      cyc($urandom_range(0,40) == 0, c[0], c[1], c[2], c[3], c[4], c[5] | c[6],
          2'($urandom), 4'($urandom), 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
